// File: rtl/seq_comparator_pkg.sv
// Shared definitions for the sequential digit-serial comparator:
// mode encodings, FSM state encoding and a width helper.
package seq_comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] MODE_EQ  = 3'b000;
  localparam logic [2:0] MODE_NEQ = 3'b001;
  localparam logic [2:0] MODE_LT  = 3'b010;
  localparam logic [2:0] MODE_GE  = 3'b011;
  localparam logic [2:0] MODE_GT  = 3'b100;
  localparam logic [2:0] MODE_LE  = 3'b101;

  // Bits needed to index digits 0..(width/digit - 1); never less than one.
  function automatic int digit_idx_w(input int width, input int digit);
    return (width / digit > 1) ? $clog2(width / digit) : 1;
  endfunction

endpackage

// File: rtl/seq_comparator_digit_cmp.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module digit_cmp #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             o_eq,
  output logic             o_lt,
  output logic             o_gt
);

  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a <  i_b);
  assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/seq_comparator.sv
// Digit-serial relational comparator, MSB digit first, stopping at the
// first differing digit.
//   state | meaning
//   IDLE  | waiting for start; operands free
//   RUN   | comparing digit r_idx each edge
//   DONE  | one-cycle done pulse; start here chains straight into RUN
module seq_comparator
  import seq_comparator_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int SIGNED_CMP = 0,
  parameter int CW         = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic             result,
  output logic [WIDTH-1:0] bitwise,
  output logic [CW-1:0]    cycles
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = digit_idx_w(WIDTH, DIGIT);
  // Flipping the sign bit maps two's complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SIGN_FLIP =
    (SIGNED_CMP != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic [2:0]       r_mode;
  logic [IW-1:0]    r_idx;
  logic             r_result;
  logic [WIDTH-1:0] r_bitwise;
  logic [CW-1:0]    r_cycles;

  logic [WIDTH-1:0] w_a_cmp, w_b_cmp;
  logic [DIGIT-1:0] w_dig_a, w_dig_b;
  int               w_base;
  logic             w_eq, w_lt, w_gt;
  logic             w_accept, w_last, w_finish, w_res;

  assign w_a_cmp  = r_a ^ SIGN_FLIP;
  assign w_b_cmp  = r_b ^ SIGN_FLIP;
  assign w_base   = WIDTH - 1 - int'(r_idx) * DIGIT;
  assign w_dig_a  = w_a_cmp[w_base -: DIGIT];
  assign w_dig_b  = w_b_cmp[w_base -: DIGIT];
  assign w_accept = start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_last   = (r_idx == IW'(NDIG - 1));
  assign w_finish = (r_state == ST_RUN) && (!w_eq || w_last);

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .i_a  (w_dig_a),
    .i_b  (w_dig_b),
    .o_eq (w_eq),
    .o_lt (w_lt),
    .o_gt (w_gt)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN:  if (w_finish) w_next = ST_DONE;
      ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
    done  = (r_state == ST_DONE);
  end

  // On the finishing edge w_eq is only 1 if every digit matched.
  always_comb begin
    w_res = 1'b0;
    case (r_mode)
      MODE_EQ:  w_res = w_eq;
      MODE_NEQ: w_res = !w_eq;
      MODE_LT:  w_res = w_lt;
      MODE_GE:  w_res = !w_lt;
      MODE_GT:  w_res = w_gt;
      MODE_LE:  w_res = !w_gt;
      default:  w_res = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_mode    <= '0;
      r_idx     <= '0;
      r_result  <= 1'b0;
      r_bitwise <= '0;
      r_cycles  <= '0;
    end else begin
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_mode <= mode;
        r_idx  <= '0;
      end else if (r_state == ST_RUN && !w_finish) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_finish) begin
        r_result  <= w_res;
        r_bitwise <= (r_mode == MODE_NEQ) ? (r_a ^ r_b) : ~(r_a ^ r_b);
        r_cycles  <= CW'(r_idx) + CW'(1);
      end
    end
  end

  assign result  = r_result;
  assign bitwise = r_bitwise;
  assign cycles  = r_cycles;

endmodule
